// File: rtl/as2650_bus_arbiter.sv
// as2650_bus_arbiter
//   Shares the AS2650 external memory/IO bus between the CPU core and one
//   DMA requester. Every access runs IDLE -> SETUP -> STROBE x (WAIT_STATES+1)
//   -> DONE, and the winner's acknowledge is pulsed in DONE. When both sides
//   request in the same IDLE cycle, the side that did not own the previous
//   access wins.
//
// Ports
//   wb_clk_i, wb_rst_n          clock, synchronous active-low reset
//   cpu_opreq/rw/m_io/adr/dout  CPU request side; cpu_opack is its ack pulse
//   dma_req/we/adr/dout         DMA request side; dma_ack is its ack pulse
//   rdata                       read data, valid in the ack cycle, then held
//   ext_*                       external bus pins (all registered)
//   grant_dma                   owner of the current or most recent access
module as2650_bus_arbiter #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ADR_W       = 13
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             cpu_opreq,
    input  logic             cpu_rw,
    input  logic             cpu_m_io,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic [7:0]       cpu_dout,
    output logic             cpu_opack,
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [ADR_W-1:0] dma_adr,
    input  logic [7:0]       dma_dout,
    output logic             dma_ack,
    output logic [7:0]       rdata,
    output logic [ADR_W-1:0] ext_adr,
    input  logic [7:0]       ext_din,
    output logic [7:0]       ext_dout,
    output logic             ext_oeb,
    output logic             ext_cs_n,
    output logic             ext_oe_n,
    output logic             ext_we_n,
    output logic             ext_m_io,
    output logic             grant_dma
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        DONE
    } state_t;

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             wr, wr_nxt;
    logic             last_owner, last_owner_nxt;   // 1 = DMA
    logic             grant_nxt;
    logic [ADR_W-1:0] adr_nxt;
    logic [7:0]       dout_nxt;
    logic             m_io_nxt;
    logic [7:0]       rdata_nxt;
    logic             pick_dma, pick_cpu;
    logic             busy_nxt;
    logic             cs_n_nxt, oe_n_nxt, we_n_nxt, oeb_nxt;
    logic             opack_nxt, dma_ack_nxt;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        wr_nxt         = wr;
        last_owner_nxt = last_owner;
        grant_nxt      = grant_dma;
        adr_nxt        = ext_adr;
        dout_nxt       = ext_dout;
        m_io_nxt       = ext_m_io;
        rdata_nxt      = rdata;
        // Round-robin tie break: the side that did not own the last access wins.
        pick_dma       = dma_req && (!cpu_opreq || !last_owner);
        pick_cpu       = cpu_opreq && (!dma_req || last_owner);

        unique case (state)
            IDLE: begin
                if (pick_dma) begin
                    state_nxt      = SETUP;
                    wr_nxt         = dma_we;
                    adr_nxt        = dma_adr;
                    dout_nxt       = dma_dout;
                    m_io_nxt       = 1'b1;
                    grant_nxt      = 1'b1;
                    last_owner_nxt = 1'b1;
                end else if (pick_cpu) begin
                    state_nxt      = SETUP;
                    wr_nxt         = cpu_rw;
                    adr_nxt        = cpu_adr;
                    dout_nxt       = cpu_dout;
                    m_io_nxt       = cpu_m_io;
                    grant_nxt      = 1'b0;
                    last_owner_nxt = 1'b0;
                end
            end
            SETUP: begin
                cnt_nxt   = WS_LOAD;
                state_nxt = STROBE;
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                    if (!wr) begin
                        rdata_nxt = ext_din;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Pin values are derived from the state being entered so that every
        // output is a flop that changes on the same edge as the state.
        busy_nxt    = (state_nxt != IDLE);
        cs_n_nxt    = !busy_nxt;
        oe_n_nxt    = !(!wr_nxt && (state_nxt == SETUP || state_nxt == STROBE));
        we_n_nxt    = !(wr_nxt && state_nxt == STROBE);
        oeb_nxt     = !(wr_nxt && busy_nxt);
        opack_nxt   = (state_nxt == DONE) && !grant_nxt;
        dma_ack_nxt = (state_nxt == DONE) && grant_nxt;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            wr         <= 1'b0;
            last_owner <= 1'b1;
            grant_dma  <= 1'b0;
            ext_adr    <= '0;
            ext_dout   <= '0;
            ext_m_io   <= 1'b1;
            rdata      <= '0;
            ext_cs_n   <= 1'b1;
            ext_oe_n   <= 1'b1;
            ext_we_n   <= 1'b1;
            ext_oeb    <= 1'b1;
            cpu_opack  <= 1'b0;
            dma_ack    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wr         <= wr_nxt;
            last_owner <= last_owner_nxt;
            grant_dma  <= grant_nxt;
            ext_adr    <= adr_nxt;
            ext_dout   <= dout_nxt;
            ext_m_io   <= m_io_nxt;
            rdata      <= rdata_nxt;
            ext_cs_n   <= cs_n_nxt;
            ext_oe_n   <= oe_n_nxt;
            ext_we_n   <= we_n_nxt;
            ext_oeb    <= oeb_nxt;
            cpu_opack  <= opack_nxt;
            dma_ack    <= dma_ack_nxt;
        end
    end

endmodule

// File: tb/tb_as2650_bus_arbiter.sv
// tb_as2650_bus_arbiter
//   Directed bench for as2650_bus_arbiter with WAIT_STATES=1, plus a second
//   instance with WAIT_STATES=0 sharing the same inputs for the latency check.
module tb_as2650_bus_arbiter;

    localparam int unsigned WS = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_opreq, cpu_rw, cpu_m_io;
    logic [12:0] cpu_adr;
    logic [7:0]  cpu_dout;
    logic        dma_req, dma_we;
    logic [12:0] dma_adr;
    logic [7:0]  dma_dout;
    logic [7:0]  ext_din;

    logic        cpu_opack, dma_ack, ext_oeb, ext_cs_n, ext_oe_n, ext_we_n, ext_m_io, grant_dma;
    logic [7:0]  rdata, ext_dout;
    logic [12:0] ext_adr;

    logic        cpu_opack0, dma_ack0, ext_oeb0, ext_cs_n0, ext_oe_n0, ext_we_n0, ext_m_io0, grant_dma0;
    logic [7:0]  rdata0, ext_dout0;
    logic [12:0] ext_adr0;

    always #5 clk = ~clk;

    as2650_bus_arbiter #(.WAIT_STATES(WS), .ADR_W(13)) u_dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .cpu_opreq(cpu_opreq), .cpu_rw(cpu_rw), .cpu_m_io(cpu_m_io),
        .cpu_adr(cpu_adr), .cpu_dout(cpu_dout), .cpu_opack(cpu_opack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr),
        .dma_dout(dma_dout), .dma_ack(dma_ack), .rdata(rdata),
        .ext_adr(ext_adr), .ext_din(ext_din), .ext_dout(ext_dout),
        .ext_oeb(ext_oeb), .ext_cs_n(ext_cs_n), .ext_oe_n(ext_oe_n),
        .ext_we_n(ext_we_n), .ext_m_io(ext_m_io), .grant_dma(grant_dma)
    );

    as2650_bus_arbiter #(.WAIT_STATES(0), .ADR_W(13)) u_dut_ws0 (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .cpu_opreq(cpu_opreq), .cpu_rw(cpu_rw), .cpu_m_io(cpu_m_io),
        .cpu_adr(cpu_adr), .cpu_dout(cpu_dout), .cpu_opack(cpu_opack0),
        .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr),
        .dma_dout(dma_dout), .dma_ack(dma_ack0), .rdata(rdata0),
        .ext_adr(ext_adr0), .ext_din(ext_din), .ext_dout(ext_dout0),
        .ext_oeb(ext_oeb0), .ext_cs_n(ext_cs_n0), .ext_oe_n(ext_oe_n0),
        .ext_we_n(ext_we_n0), .ext_m_io(ext_m_io0), .grant_dma(grant_dma0)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated access; returns the cycle on which the WAIT_STATES=0
    // instance acknowledged (0 if it never did).
    task automatic run_single(input string tag, input bit use_dma, input bit wr, input bit mio,
                              input logic [12:0] adr, input logic [7:0] data,
                              input logic [7:0] din, output int lat0);
        int  lat = 0, n_cs = 0, n_oe = 0, n_we = 0, n_oeb = 0;
        int  n_acks = 0, n_other = 0, n_bad = 0;
        bit  done = 0, my_ack, other_ack, exp_mio;
        lat0    = 0;
        exp_mio = use_dma ? 1'b1 : mio;
        ext_din = din;
        if (use_dma) begin
            dma_req = 1; dma_we = wr; dma_adr = adr; dma_dout = data;
        end else begin
            cpu_opreq = 1; cpu_rw = wr; cpu_m_io = mio; cpu_adr = adr; cpu_dout = data;
        end
        for (int t = 1; t <= 20 && !done; t++) begin
            tick();
            if (!ext_cs_n) begin
                n_cs++;
                if (ext_adr !== adr || ext_m_io !== exp_mio || grant_dma !== use_dma) n_bad++;
            end
            if (!ext_oe_n) n_oe++;
            if (!ext_we_n) n_we++;
            if (!ext_oeb) begin
                n_oeb++;
                if (ext_dout !== data) n_bad++;
            end
            my_ack    = use_dma ? dma_ack : cpu_opack;
            other_ack = use_dma ? cpu_opack : dma_ack;
            if (other_ack) n_other++;
            if (my_ack) begin
                n_acks++;
                if (lat == 0) lat = t;
                if (!wr && rdata !== din) n_bad++;
                if (use_dma) dma_req = 0; else cpu_opreq = 0;
            end
            if (lat0 == 0 && (cpu_opack0 || dma_ack0)) lat0 = t;
            if (lat != 0 && ext_cs_n) done = 1;
        end
        check({tag, "_latency"},  lat,     3 + WS);
        check({tag, "_cs_cyc"},   n_cs,    3 + WS);
        check({tag, "_oe_cyc"},   n_oe,    wr ? 0 : 2 + WS);
        check({tag, "_we_cyc"},   n_we,    wr ? WS + 1 : 0);
        check({tag, "_oeb_cyc"},  n_oeb,   wr ? 3 + WS : 0);
        check({tag, "_ack_cnt"},  n_acks,  1);
        check({tag, "_other_ack"}, n_other, 0);
        check({tag, "_bus_vals"}, n_bad,   0);
        if (!wr) check({tag, "_rdata_held"}, rdata, din);
    endtask

    initial begin
        int lat0;
        int ack_t[$];
        bit ack_o[$];
        int d, s, c, n_early;

        rst_n = 0;
        cpu_opreq = 0; cpu_rw = 0; cpu_m_io = 1; cpu_adr = '0; cpu_dout = '0;
        dma_req = 0; dma_we = 0; dma_adr = '0; dma_dout = '0; ext_din = '0;
        tick(); tick();

        check("rst_cs_n",  ext_cs_n,  1);
        check("rst_oe_n",  ext_oe_n,  1);
        check("rst_we_n",  ext_we_n,  1);
        check("rst_oeb",   ext_oeb,   1);
        check("rst_adr",   ext_adr,   0);
        check("rst_dout",  ext_dout,  0);
        check("rst_rdata", rdata,     0);
        check("rst_m_io",  ext_m_io,  1);
        check("rst_acks",  {cpu_opack, dma_ack}, 0);
        check("rst_grant", grant_dma, 0);
        rst_n = 1;
        tick();

        // CPU memory read, both instances in parallel
        run_single("cpu_rd", 1'b0, 1'b0, 1'b1, 13'h1234, 8'h00, 8'hA5, lat0);
        check("ws0_latency", lat0, 3);
        check("ws0_rdata", rdata0, 8'hA5);
        check("ws0_idle_pins", {ext_cs_n0, ext_oe_n0, ext_we_n0, ext_oeb0, ext_m_io0, grant_dma0, dma_ack0},
              7'b1111100);
        check("ws0_adr_dout", {ext_adr0, ext_dout0}, {13'h1234, 8'h00});

        // DMA memory write
        run_single("dma_wr", 1'b1, 1'b1, 1'b1, 13'h0042, 8'h3C, 8'h00, lat0);
        check("dma_wr_grant", grant_dma, 1);

        // IO write from CPU
        run_single("cpu_io_wr", 1'b0, 1'b1, 1'b0, 13'h0005, 8'h7F, 8'h00, lat0);

        // Simultaneous requests held from reset: CPU wins first, then alternates
        rst_n = 0; tick(); rst_n = 1;
        cpu_rw = 0; cpu_m_io = 1; cpu_adr = 13'h0100;
        dma_we = 0; dma_adr = 13'h0200; ext_din = 8'h66;
        cpu_opreq = 1; dma_req = 1;
        for (int t = 1; t <= 24; t++) begin
            tick();
            if (cpu_opack) begin ack_t.push_back(t); ack_o.push_back(1'b0); end
            if (dma_ack)   begin ack_t.push_back(t); ack_o.push_back(1'b1); end
            if (ack_t.size() >= 4) begin cpu_opreq = 0; dma_req = 0; end
        end
        check("rr_ack_count", ack_t.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ack_t.size()) begin
                check($sformatf("rr_ack%0d_time", i), ack_t[i], 4 + 5 * i);
                check($sformatf("rr_ack%0d_owner", i), ack_o[i], i % 2);
            end
        end

        // Contention: CPU read arrives during a DMA write strobe
        dma_req = 1; dma_we = 1; dma_adr = 13'h0ABC; dma_dout = 8'h11;
        tick(); tick();
        cpu_opreq = 1; cpu_rw = 0; cpu_m_io = 1; cpu_adr = 13'h0777; ext_din = 8'h5A;
        d = 0; s = 0; c = 0; n_early = 0;
        for (int t = 3; t <= 20 && c == 0; t++) begin
            tick();
            if (d == 0 && !ext_oe_n) n_early++;
            if (dma_ack) begin d = t; dma_req = 0; end
            if (s == 0 && !ext_cs_n && !grant_dma) s = t;
            if (cpu_opack) begin
                c = t; cpu_opreq = 0;
                check("cont_rdata", rdata, 8'h5A);
            end
        end
        check("cont_dma_ack", d, 3 + WS);
        check("cont_cpu_setup", s, 5 + WS);
        check("cont_cpu_ack", c, 7 + 2 * WS);
        check("cont_no_early_oe", n_early, 0);
        tick();

        // Reset in the middle of a CPU write strobe
        cpu_opreq = 1; cpu_rw = 1; cpu_m_io = 1; cpu_adr = 13'h0ABC; cpu_dout = 8'h55;
        tick(); tick();
        check("mid_we_active", ext_we_n, 0);
        rst_n = 0; cpu_opreq = 0;
        tick();
        check("mid_rst_pins", {ext_cs_n, ext_oe_n, ext_we_n, ext_oeb}, 4'hF);
        check("mid_rst_adr", ext_adr, 0);
        check("mid_rst_ack", cpu_opack, 0);
        rst_n = 1;
        tick(); tick();
        check("mid_rst_no_ack", {cpu_opack, ext_cs_n}, 2'b01);
        run_single("post_rst_rd", 1'b0, 1'b0, 1'b1, 13'h0123, 8'h00, 8'h3C, lat0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
